// File: rtl/circuit_test_pkg.sv
// circuit_test_pkg: shared FSM state type and default parameters for the circuit test sequencer.
package circuit_test_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam int DEF_IN_WIDTH = 4;
    localparam int DEF_SETTLE_CYCLES = 16;
    localparam int DEF_SAMPLES = 8;
    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/circuit_test_sequencer_sync2.sv
// sync2: two-flop synchronizer with synchronous active-low clear.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk)
        if (!rst_n) {q, meta} <= 2'b00;
        else {q, meta} <= {meta, d};
endmodule

// File: rtl/circuit_test_sequencer.sv
// circuit_test_sequencer: sweeps every input pattern of an evolved circuit, records truth table and instability.
module circuit_test_sequencer
    import circuit_test_pkg::*;
#(
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLES = DEF_SAMPLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [IN_WIDTH-1:0]   dut_in,
    input  logic                  dut_out,
    output logic [2**IN_WIDTH-1:0] truth_table,
    output logic [2**IN_WIDTH-1:0] unstable_mask,
    output logic [IN_WIDTH:0]     unstable_count
);
    localparam int NPAT = 2**IN_WIDTH;
    localparam int CW = $clog2(max2(SETTLE_CYCLES, SAMPLES));
    localparam int UCW = IN_WIDTH + 1;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic s, ref_q, diff, settle_end, sample_end, last_pat, ref_v, diff_v;
    sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(dut_out), .q(s));
    assign busy = state != IDLE;
    assign done = state == DONE;
    // ref_v/diff_v fold the current sample in, so SAMPLES = 1 records s directly with no diff
    always_comb begin
        settle_end = cnt == CW'(SETTLE_CYCLES - 1);
        sample_end = cnt == CW'(SAMPLES - 1);
        last_pat = dut_in == IN_WIDTH'(NPAT - 1);
        ref_v = (cnt == '0) ? s : ref_q;
        diff_v = (cnt != '0) && (diff || (s != ref_q));
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SETTLE : IDLE;
            SETTLE:  state_nx = settle_end ? SAMPLE : SETTLE;
            SAMPLE:  state_nx = sample_end ? (last_pat ? DONE : SETTLE) : SAMPLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            dut_in <= '0;
            truth_table <= '0;
            unstable_mask <= '0;
            unstable_count <= '0;
            ref_q <= 1'b0;
            diff <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE:
                    if (start) begin
                        truth_table <= '0;
                        unstable_mask <= '0;
                        unstable_count <= '0;
                        dut_in <= '0;
                        cnt <= '0;
                    end
                SETTLE: cnt <= settle_end ? '0 : cnt + 1'b1;
                SAMPLE: begin
                    ref_q <= ref_v;
                    diff <= diff_v;
                    cnt <= cnt + 1'b1;
                    if (sample_end) begin
                        truth_table[dut_in] <= ref_v;
                        unstable_mask[dut_in] <= diff_v;
                        unstable_count <= unstable_count + UCW'(diff_v);
                        cnt <= '0;
                        if (!last_pat) dut_in <= dut_in + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_circuit_test_sequencer.sv
// tb_circuit_test_sequencer: directed runs with a done-triggered scoreboard monitor per sequencer instance.
module tb_circuit_test_sequencer;
    typedef struct {
        int unsigned e0;
        int unsigned lat;
        logic [15:0] tt;
        logic [15:0] care;
        logic [15:0] um;
        logic [4:0]  uc;
    } exp_t;
    exp_t q1[$];
    exp_t q2[$];
    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start2 = 1'b0;
    logic mode = 1'b0;
    logic osc = 1'b0, par_d = 1'b0;
    logic busy1, done1, busy2, done2, dut_out1, dut_out2;
    logic [3:0] dut_in1, dut_in2;
    logic [15:0] tt1, um1, tt2, um2;
    logic [4:0] uc1, uc2;
    bit done1_prev = 0, done2_prev = 0;

    circuit_test_sequencer u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .dut_in(dut_in1), .dut_out(dut_out1), .truth_table(tt1),
        .unstable_mask(um1), .unstable_count(uc1)
    );
    circuit_test_sequencer #(.IN_WIDTH(4), .SETTLE_CYCLES(3), .SAMPLES(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .dut_in(dut_in2), .dut_out(dut_out2), .truth_table(tt2),
        .unstable_mask(um2), .unstable_count(uc2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        osc <= ~osc;
        par_d <= ^dut_in1;
    end
    // mode 0: parity with one register of delay; mode 1: oscillates on pattern 5, otherwise constant 1
    assign dut_out1 = mode ? ((dut_in1 == 4'd5) ? osc : 1'b1) : par_d;
    assign dut_out2 = ^dut_in2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done1) begin
            if (done1_prev) chk("done1_width", done1_prev, 0);
            else if (q1.size() == 0) chk("done1_unexpected", done1, 0);
            else begin
                e = q1.pop_front();
                chk("done1_latency", cyc - e.e0, e.lat);
                chk("tt1", tt1 & e.care, e.tt & e.care);
                chk("um1", um1, e.um);
                chk("uc1", uc1, e.uc);
            end
        end
        done1_prev = done1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (done2) begin
            if (done2_prev) chk("done2_width", done2_prev, 0);
            else if (q2.size() == 0) chk("done2_unexpected", done2, 0);
            else begin
                e = q2.pop_front();
                chk("done2_latency", cyc - e.e0, e.lat);
                chk("tt2", tt2 & e.care, e.tt & e.care);
                chk("um2", um2, e.um);
                chk("uc2", uc2, e.uc);
            end
        end
        done2_prev = done2;
    end

    task automatic start_run(input bit which, input logic [15:0] tt, input logic [15:0] care,
                             input logic [15:0] um, input logic [4:0] uc, output int unsigned e0);
        exp_t x;
        @(negedge clk);
        if (which) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
        e0 = cyc;
        x.e0 = cyc; x.lat = which ? 64 : 384;
        x.tt = tt; x.care = care; x.um = um; x.uc = uc;
        if (which) q2.push_back(x); else q1.push_back(x);
        chk("busy_after_start", which ? busy2 : busy1, 1);
    endtask

    task automatic wait_idle(input bit which, input int bound);
        int n = 0;
        while (((which ? q2.size() : q1.size()) != 0 || (which ? busy2 : busy1)) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("run_timeout", n >= bound, 0);
    endtask

    initial begin
        int unsigned e0;
        exp_t x;
        int n;
        // reset held with start high
        start1 = 1'b1; start2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_dut_in", dut_in1, 0);
        chk("rst_tt", tt1, 0);
        chk("rst_um", um1, 0);
        chk("rst_uc", uc1, 0);
        chk("rst_busy2", busy2, 0);
        start1 = 1'b0; start2 = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy1, 0);

        // parity, defaults
        start_run(0, 16'h6996, 16'hFFFF, 16'h0000, 5'd0, e0);
        wait_idle(0, 500);

        // oscillator on pattern 5
        mode = 1'b1;
        start_run(0, 16'hFFFF, 16'hFFDF, 16'h0020, 5'd1, e0);
        wait_idle(0, 500);
        mode = 1'b0;

        // start pulsed mid-run, then held high past done
        start_run(0, 16'h6996, 16'hFFFF, 16'h0000, 5'd0, e0);
        repeat (100) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (cyc < e0 + 380) @(negedge clk);
        start1 = 1'b1;
        x.e0 = e0 + 386; x.lat = 384; x.tt = 16'h6996; x.care = 16'hFFFF; x.um = 0; x.uc = 0;
        q1.push_back(x);
        while (cyc < e0 + 385) @(negedge clk);
        chk("idle_gap_busy", busy1, 0);
        chk("idle_gap_tt_held", tt1, 16'h6996);
        @(negedge clk);
        chk("recapture_busy", busy1, 1);
        chk("recapture_tt_clear", tt1, 0);
        chk("recapture_um_clear", um1, 0);
        start1 = 1'b0;
        wait_idle(0, 500);

        // reset for one cycle while dut_in = 7
        start_run(0, 16'h6996, 16'hFFFF, 16'h0000, 5'd0, e0);
        x = q1.pop_back();
        n = 0;
        while (dut_in1 != 4'd7 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_pattern7", dut_in1, 7);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy", busy1, 0);
        chk("abort_done", done1, 0);
        chk("abort_dut_in", dut_in1, 0);
        chk("abort_tt", tt1, 0);
        chk("abort_um", um1, 0);
        chk("abort_uc", uc1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (420) @(negedge clk);
        chk("abort_stays_idle", busy1, 0);
        start_run(0, 16'h6996, 16'hFFFF, 16'h0000, 5'd0, e0);
        wait_idle(0, 500);

        // minimal settle/samples with zero-delay parity
        start_run(1, 16'h6996, 16'hFFFF, 16'h0000, 5'd0, e0);
        wait_idle(1, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
